// File: rtl/t_switch_sched.sv
// t_switch_sched: two-register route/allocate stage for one fat-tree T-switch.
// Define T_SCHED_STATS_EN to add the saturating deflect_cnt output.
module t_switch_sched #(
  parameter int num_leaves = 8,
  parameter int payload_sz = 32,
  parameter int level      = 1,
  parameter int pos        = 0,
  parameter int addr_sz    = $clog2(num_leaves),
  parameter int p_sz       = 1 + addr_sz + payload_sz
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [p_sz-1:0] l_bus_i,
  input  logic [p_sz-1:0] r_bus_i,
  input  logic [p_sz-1:0] u_bus_i,
  output logic [p_sz-1:0] l_bus_o,
  output logic [p_sz-1:0] r_bus_o,
  output logic [p_sz-1:0] u_bus_o
`ifdef T_SCHED_STATS_EN
  ,
  output logic [15:0]     deflect_cnt
`endif
);

  localparam logic [addr_sz-1:0] POS_V = addr_sz'(pos);

  // Index 0 = left, 1 = right, 2 = up, for both inputs and outputs.
  logic [p_sz-1:0] w_in  [3];
  logic [p_sz-1:0] r_pkt [3];
  logic [1:0]      r_dir [3];
  logic [p_sz-1:0] r_out [3];
  logic            r_pri;

  logic [2:0] w_val;
  logic [2:0] w_free;
  logic [2:0] w_gnt;
  logic [2:0] w_asg;
  logic [2:0] w_has;
  logic [1:0] w_src [3];
  logic [1:0] w_ord [3];
  logic [1:0] w_c   [3];
  logic [1:0] w_k;
  logic [1:0] w_o;
  logic       w_clash;

  function automatic logic [1:0] f_dir(
    input logic               v,
    input logic [addr_sz-1:0] a
  );
    if (!v)
      return 2'b00;
    else if ((a >> level) != POS_V)
      return 2'b11;
    else if (a[level-1])
      return 2'b10;
    else
      return 2'b01;
  endfunction

  assign w_in[0] = l_bus_i;
  assign w_in[1] = r_bus_i;
  assign w_in[2] = u_bus_i;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 3; i++) begin
        r_pkt[i] <= '0;
        r_dir[i] <= 2'b00;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        r_pkt[i] <= w_in[i];
        r_dir[i] <= f_dir(w_in[i][p_sz-1],
                          w_in[i][p_sz-2 -: addr_sz]);
      end
    end
  end

  assign w_val[0] = r_dir[0] != 2'b00;
  assign w_val[1] = r_dir[1] != 2'b00;
  assign w_val[2] = r_dir[2] != 2'b00;

  // Grant pass on desired outputs, then deflection pass for the losers.
  always_comb begin
    w_free = 3'b111;
    w_gnt  = 3'b000;
    w_asg  = 3'b000;
    w_has  = 3'b000;
    w_src  = '{default: 2'd0};
    w_c    = '{default: 2'd0};
    w_ord  = '{2'd2,
               r_pri ? 2'd1 : 2'd0,
               r_pri ? 2'd0 : 2'd1};
    w_k    = 2'd0;
    w_o    = 2'd0;
    for (int k = 0; k < 3; k++) begin
      w_k = w_ord[k];
      w_o = r_dir[w_k] - 2'd1;
      if (w_val[w_k] && w_free[w_o]) begin
        w_free[w_o] = 1'b0;
        w_has[w_o]  = 1'b1;
        w_src[w_o]  = w_k;
        w_gnt[w_k]  = 1'b1;
      end
    end
    w_asg = w_gnt;
    for (int k = 0; k < 3; k++) begin
      w_k = w_ord[k];
      w_c = '{w_k, 2'd2, (w_k == 2'd0) ? 2'd1 : 2'd0};
      for (int j = 0; j < 3; j++) begin
        if (w_val[w_k] && !w_asg[w_k] && w_free[w_c[j]]) begin
          w_free[w_c[j]] = 1'b0;
          w_has[w_c[j]]  = 1'b1;
          w_src[w_c[j]]  = w_k;
          w_asg[w_k]     = 1'b1;
        end
      end
    end
  end

  assign w_clash = w_val[0] && (r_dir[0] == r_dir[1]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 3; i++)
        r_out[i] <= '0;
      r_pri <= 1'b0;
    end else begin
      for (int i = 0; i < 3; i++)
        r_out[i] <= w_has[i] ? r_pkt[w_src[i]] : '0;
      r_pri <= r_pri ^ w_clash;
    end
  end

  assign l_bus_o = r_out[0];
  assign r_bus_o = r_out[1];
  assign u_bus_o = r_out[2];

`ifdef T_SCHED_STATS_EN
  logic [2:0]  w_miss;
  logic [1:0]  w_ndef;
  logic [16:0] w_sum;
  logic [15:0] r_cnt;

  assign w_miss = w_val & ~w_gnt;
  assign w_ndef = 2'(w_miss[0]) + 2'(w_miss[1]) + 2'(w_miss[2]);
  assign w_sum  = {1'b0, r_cnt} + 17'(w_ndef);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_cnt <= 16'h0000;
    else
      r_cnt <= w_sum[16] ? 16'hFFFF : w_sum[15:0];
  end

  assign deflect_cnt = r_cnt;
`endif

endmodule

// File: tb/tb_t_switch_sched.sv
// tb_t_switch_sched: random and directed stimulus against a reference model.
// Build with T_SCHED_STATS_EN to also check deflect_cnt.
module tb_t_switch_sched;

  localparam int PS = 36;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [PS-1:0] l_i, r_i, u_i;
  logic [PS-1:0] l_o, r_o, u_o;
`ifdef T_SCHED_STATS_EN
  logic [15:0]   dcnt;
`endif

  int n_chk = 0;
  int n_bad = 0;

  logic [PS-1:0] m_s1  [3];
  logic [PS-1:0] m_out [3];
  int            m_pri;
  int            m_cnt;

  always #5 clk = ~clk;

  t_switch_sched dut (
    .clk     (clk),
    .reset_n (reset_n),
    .l_bus_i (l_i),
    .r_bus_i (r_i),
    .u_bus_i (u_i),
    .l_bus_o (l_o),
    .r_bus_o (r_o),
    .u_bus_o (u_o)
`ifdef T_SCHED_STATS_EN
    ,
    .deflect_cnt (dcnt)
`endif
  );

  function automatic logic [PS-1:0] mk(
    input logic v, input int a, input int pl
  );
    return {v, a[2:0], pl};
  endfunction

  task automatic chk(
    input string tag, input logic [63:0] got, input logic [63:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_s1[i]  = '0;
      m_out[i] = '0;
    end
    m_pri = 0;
    m_cnt = 0;
  endtask

  // Leaves 0 and 1 are below (level 1, pos 0): addr<2 goes down, else up.
  task automatic model_step(
    input logic [PS-1:0] nl, input logic [PS-1:0] nr, input logic [PS-1:0] nu
  );
    int want[3];
    int owner[3];
    int ord[3];
    int cand[3];
    bit placed[3];
    int a;
    int nd;
    for (int i = 0; i < 3; i++) begin
      want[i] = -1;
      owner[i] = -1;
      placed[i] = 0;
      if (m_s1[i][PS-1]) begin
        a = int'(m_s1[i][PS-2 -: 3]);
        want[i] = (a < 2) ? a : 2;
      end
    end
    ord = '{2, m_pri, 1 - m_pri};
    for (int k = 0; k < 3; k++) begin
      int i = ord[k];
      if (want[i] >= 0 && owner[want[i]] < 0) begin
        owner[want[i]] = i;
        placed[i] = 1;
      end
    end
    nd = 0;
    for (int k = 0; k < 3; k++) begin
      int i = ord[k];
      if (want[i] >= 0 && !placed[i]) begin
        nd++;
        cand = '{i, 2, (i == 0) ? 1 : 0};
        for (int j = 0; j < 3; j++)
          if (!placed[i] && owner[cand[j]] < 0) begin
            owner[cand[j]] = i;
            placed[i] = 1;
          end
      end
    end
    for (int o = 0; o < 3; o++)
      m_out[o] = (owner[o] >= 0) ? m_s1[owner[o]] : '0;
    if (want[0] >= 0 && want[0] == want[1])
      m_pri = 1 - m_pri;
    m_cnt = (m_cnt + nd > 65535) ? 65535 : m_cnt + nd;
    m_s1[0] = nl;
    m_s1[1] = nr;
    m_s1[2] = nu;
  endtask

  task automatic tick(input bit do_chk);
    logic [PS-1:0] a, b, c;
    a = l_i;
    b = r_i;
    c = u_i;
    @(posedge clk);
    model_step(a, b, c);
    #1;
    if (do_chk) begin
      chk("l_bus_o", 64'(l_o), 64'(m_out[0]));
      chk("r_bus_o", 64'(r_o), 64'(m_out[1]));
      chk("u_bus_o", 64'(u_o), 64'(m_out[2]));
`ifdef T_SCHED_STATS_EN
      chk("deflect_cnt", 64'(dcnt), 64'(m_cnt));
`endif
    end
  endtask

  task automatic drive(
    input logic [PS-1:0] nl, input logic [PS-1:0] nr, input logic [PS-1:0] nu
  );
    l_i = nl;
    r_i = nr;
    u_i = nu;
  endtask

  task automatic mid_reset(input string tag);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    chk({tag, "_l"}, 64'(l_o), 64'd0);
    chk({tag, "_r"}, 64'(r_o), 64'd0);
    chk({tag, "_u"}, 64'(u_o), 64'd0);
`ifdef T_SCHED_STATS_EN
    chk({tag, "_cnt"}, 64'(dcnt), 64'd0);
`endif
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic rr_chk(input int j);
    if (j % 2 == 0) begin
      chk("rr_win", 64'(u_o), 64'(mk(1, 4, 'h10 + j)));
      chk("rr_lose", 64'(r_o), 64'(mk(1, 4, 'h20 + j)));
    end else begin
      chk("rr_win", 64'(u_o), 64'(mk(1, 4, 'h20 + j)));
      chk("rr_lose", 64'(l_o), 64'(mk(1, 4, 'h10 + j)));
    end
  endtask

  initial begin
    reset_n = 1'b0;
    model_reset();
    drive(mk(1, 1, 1), mk(1, 0, 2), mk(1, 4, 3));
    repeat (3) @(posedge clk);
    #1;
    chk("rst_l", 64'(l_o), 64'd0);
    chk("rst_r", 64'(r_o), 64'd0);
    chk("rst_u", 64'(u_o), 64'd0);
`ifdef T_SCHED_STATS_EN
    chk("rst_cnt", 64'(dcnt), 64'd0);
`endif
    reset_n = 1'b1;
    drive(mk(1, 1, 'h55), '0, '0);
    tick(1);
    drive('0, '0, '0);
    chk("lat1", 64'(r_o), 64'd0);
    tick(1);
    chk("lat2", 64'(r_o), 64'(mk(1, 1, 'h55)));

    drive(mk(1, 1, 'hA), mk(1, 0, 'hB), '0);
    tick(1);
    drive('0, '0, '0);
    tick(1);
    chk("plain_r", 64'(r_o), 64'(mk(1, 1, 'hA)));
    chk("plain_l", 64'(l_o), 64'(mk(1, 0, 'hB)));
    chk("plain_u", 64'(u_o), 64'd0);

    drive(mk(1, 5, 'hC), '0, mk(1, 0, 'hD));
    tick(1);
    drive('0, '0, '0);
    tick(1);
    chk("uplink_u", 64'(u_o), 64'(mk(1, 5, 'hC)));
    chk("uplink_l", 64'(l_o), 64'(mk(1, 0, 'hD)));

    for (int i = 0; i < 4; i++) begin
      drive(mk(1, 4, 'h10 + i), mk(1, 4, 'h20 + i), '0);
      tick(1);
      if (i > 0) rr_chk(i - 1);
    end
    drive('0, '0, '0);
    tick(1);
    rr_chk(3);
`ifdef T_SCHED_STATS_EN
    chk("rr_cnt", 64'(dcnt), 64'd4);
`endif

    drive(mk(1, 0, 'hF), '0, mk(1, 0, 'hE));
    tick(1);
    drive('0, '0, '0);
    tick(1);
    chk("down_l", 64'(l_o), 64'(mk(1, 0, 'hE)));
    chk("down_u", 64'(u_o), 64'(mk(1, 0, 'hF)));
`ifdef T_SCHED_STATS_EN
    chk("down_cnt", 64'(dcnt), 64'd5);

    drive(mk(1, 0, 1), mk(1, 0, 2), mk(1, 0, 3));
    repeat (35010) tick(0);
    tick(1);
    chk("sat_cnt", 64'(dcnt), 64'hFFFF);
    mid_reset("sat_rst");
`endif

    for (int c = 0; c < 400; c++) begin
      drive(mk($urandom_range(0, 3) != 0, int'($urandom_range(0, 7)),
               int'($urandom)),
            mk($urandom_range(0, 3) != 0, int'($urandom_range(0, 7)),
               int'($urandom)),
            mk($urandom_range(0, 2) == 0, int'($urandom_range(0, 7)),
               int'($urandom)));
      tick(1);
      if (c == 200) begin
        mid_reset("mid_rst");
        drive(mk(1, 6, 'h31), mk(1, 6, 'h32), '0);
        tick(1);
        drive('0, '0, '0);
        tick(1);
        chk("pri_rst", 64'(u_o), 64'(mk(1, 6, 'h31)));
      end
    end
    drive('0, '0, '0);
    tick(1);
    tick(1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
